// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares the single data-memory port between the processor
//                load/store path (p_*) and the debug/loader port (d_*).
//                Round-robin arbitration with a registered winner; one
//                transfer in flight at a time. Read data is returned through
//                per-requester holding registers with a one-cycle valid pulse.
//  Ports       : clock, reset (sync, active-low)
//                p_req/p_wren/p_addr/p_data -> p_gnt/p_rvalid/p_q  (processor)
//                d_req/d_wren/d_addr/d_data -> d_gnt/d_rvalid/d_q  (debug)
//                mem_addr/mem_wren/mem_data -> dmem, mem_q <- dmem
//                busy : high whenever the arbiter is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p_req,
    input  logic                  p_wren,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic [DATA_WIDTH-1:0] p_q,
    input  logic                  d_req,
    input  logic                  d_wren,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_q,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE  = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;

    localparam logic       c_SEL_PROC  = 1'b0;
    localparam logic       c_SEL_DEBUG = 1'b1;

    // Only latencies 1 and 2 are meaningful; anything else behaves as 1.
    localparam logic [1:0] c_READ_LAT  = (READ_LATENCY == 2) ? 2'd2 : 2'd1;

    logic [1:0]            r_state;
    logic                  r_winner;
    logic                  r_last_winner;
    logic [1:0]            r_cnt;
    logic                  r_p_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_WIDTH-1:0] r_p_q;
    logic [DATA_WIDTH-1:0] r_d_q;

    logic [1:0]            w_next_state;
    logic                  w_next_winner;
    logic                  w_win_req;
    logic                  w_win_wren;
    logic                  w_issue_go;
    logic                  w_capture;

    // The winner's request/command is sampled live during ISSUE so that a
    // requester withdrawing its request cancels the access cleanly.
    assign w_win_req  = (r_winner == c_SEL_DEBUG) ? d_req  : p_req;
    assign w_win_wren = (r_winner == c_SEL_DEBUG) ? d_wren : p_wren;

    // ------------------------------------------------------------------
    // Next-state and per-cycle control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_next_winner = r_winner;
        w_issue_go    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (p_req || d_req) begin
                    w_next_state = c_ST_ISSUE;
                    if (p_req && d_req) begin
                        // Tie goes to whoever did not win last time.
                        w_next_winner = ~r_last_winner;
                    end else begin
                        w_next_winner = d_req ? c_SEL_DEBUG : c_SEL_PROC;
                    end
                end
            end
            c_ST_ISSUE: begin
                w_next_state = c_ST_IDLE;
                if (w_win_req) begin
                    w_issue_go = 1'b1;
                    if (!w_win_wren) begin
                        w_next_state = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == 2'd1) begin
                    w_capture    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, arbitration history, latency counter and read-return registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_winner      <= c_SEL_PROC;
            r_last_winner <= c_SEL_DEBUG;
            r_cnt         <= 2'd0;
            r_p_rvalid    <= 1'b0;
            r_d_rvalid    <= 1'b0;
            r_p_q         <= '0;
            r_d_q         <= '0;
        end else begin
            r_state    <= w_next_state;
            r_winner   <= w_next_winner;
            r_p_rvalid <= w_capture && (r_winner == c_SEL_PROC);
            r_d_rvalid <= w_capture && (r_winner == c_SEL_DEBUG);
            if (w_issue_go) begin
                r_last_winner <= r_winner;
                r_cnt         <= c_READ_LAT;
            end else if (r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_capture && (r_winner == c_SEL_PROC)) begin
                r_p_q <= mem_q;
            end
            if (w_capture && (r_winner == c_SEL_DEBUG)) begin
                r_d_q <= mem_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the memory port is only non-zero during a live ISSUE cycle
    // ------------------------------------------------------------------
    assign mem_addr = w_issue_go ? ((r_winner == c_SEL_DEBUG) ? d_addr : p_addr) : '0;
    assign mem_data = w_issue_go ? ((r_winner == c_SEL_DEBUG) ? d_data : p_data) : '0;
    assign mem_wren = w_issue_go && w_win_wren;

    assign p_gnt    = w_issue_go && (r_winner == c_SEL_PROC);
    assign d_gnt    = w_issue_go && (r_winner == c_SEL_DEBUG);
    assign p_rvalid = r_p_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign p_q      = r_p_q;
    assign d_q      = r_d_q;
    assign busy     = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
